decode_cycle: RTL and testbench

//  RV32I pipeline decode stage (ID) plus ID/EX pipeline register. Consumes InstrD, PCD and PCPlus4D

---
 rtl/decode_cycle.sv | 233 +++++++++++++++++++++++
 tb/tb_decode_cycle.sv | 411 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_cycle.sv
// -----------------------------------------------------------------------------
// decode_cycle
//   RV32I decode stage (ID) with the ID/EX pipeline register.
//   - Holds the 32 x XLEN register file, written from the W stage.
//   - Decodes main/ALU control, builds the immediate, and registers everything
//     for the E stage with one cycle of latency.
//   - Same-cycle write-back bypass: a register written this cycle is seen by
//     the instruction being decoded this cycle.
//
// Ports
//   clk, rst            rising-edge clock, synchronous active-low reset
//   InstrD/PCD/PCPlus4D instruction, its PC and PC+4 from IF/ID
//   RegWriteW/RDW/ResultW  write-back port
//   FlushE              turns the next E-stage slot into a bubble
//   Rs1D, Rs2D          source indices for the hazard unit (combinational)
//   IllegalD            unsupported opcode/funct3 (combinational)
//   *E                  registered E-stage controls, operands and indices
// -----------------------------------------------------------------------------
module decode_cycle #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] InstrD,
    input  logic [XLEN-1:0] PCD,
    input  logic [XLEN-1:0] PCPlus4D,
    input  logic            RegWriteW,
    input  logic [4:0]      RDW,
    input  logic [XLEN-1:0] ResultW,
    input  logic            FlushE,
    output logic [4:0]      Rs1D,
    output logic [4:0]      Rs2D,
    output logic            IllegalD,
    output logic            RegWriteE,
    output logic [1:0]      ResultSrcE,
    output logic            MemWriteE,
    output logic            JumpE,
    output logic            BranchE,
    output logic            ALUSrcE,
    output logic [2:0]      ALUControlE,
    output logic [XLEN-1:0] RD1E,
    output logic [XLEN-1:0] RD2E,
    output logic [XLEN-1:0] ImmExtE,
    output logic [4:0]      RdE,
    output logic [4:0]      Rs1E,
    output logic [4:0]      Rs2E,
    output logic [XLEN-1:0] PCE,
    output logic [XLEN-1:0] PCPlus4E
);

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    logic [XLEN-1:0] rf [NREGS];

    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_j;
    logic [XLEN-1:0] rd1, rd2;

    logic            alu_ok;
    logic [2:0]      alu_op;

    logic            reg_write, mem_write, jump, branch, alu_src;
    logic [1:0]      result_src;
    logic [2:0]      alu_control;
    logic [XLEN-1:0] imm_ext;

    assign opcode = InstrD[6:0];
    assign funct3 = InstrD[14:12];
    assign Rs1D   = InstrD[19:15];
    assign Rs2D   = InstrD[24:20];

    assign imm_i = {{(XLEN-12){InstrD[31]}}, InstrD[31:20]};
    assign imm_s = {{(XLEN-12){InstrD[31]}}, InstrD[31:25], InstrD[11:7]};
    assign imm_b = {{(XLEN-12){InstrD[31]}}, InstrD[7], InstrD[30:25], InstrD[11:8], 1'b0};
    assign imm_j = {{(XLEN-20){InstrD[31]}}, InstrD[19:12], InstrD[20], InstrD[30:21], 1'b0};

    // x0 always reads zero; otherwise a write landing this cycle wins over
    // the stored value so ID/EX captures the fresh result.
    always_comb begin
        rd1 = '0;
        rd2 = '0;
        if (Rs1D != 5'd0)
            rd1 = (RegWriteW && RDW == Rs1D) ? ResultW : rf[Rs1D];
        if (Rs2D != 5'd0)
            rd2 = (RegWriteW && RDW == Rs2D) ? ResultW : rf[Rs2D];
    end

    // ALU function shared by R-type and I-ALU; SUB exists only for R-type.
    always_comb begin
        alu_ok = 1'b1;
        alu_op = ALU_ADD;
        case (funct3)
            3'b000:  alu_op = (opcode == OP_R && InstrD[30]) ? ALU_SUB : ALU_ADD;
            3'b010:  alu_op = ALU_SLT;
            3'b110:  alu_op = ALU_OR;
            3'b111:  alu_op = ALU_AND;
            default: alu_ok = 1'b0;
        endcase
    end

    // Main decoder. Anything unsupported leaves every control at zero (NOP).
    always_comb begin
        // NOTE: every output gets a default before the case so no path can
        // leave one unassigned and infer a latch.
        reg_write   = 1'b0;
        result_src  = 2'b00;
        mem_write   = 1'b0;
        jump        = 1'b0;
        branch      = 1'b0;
        alu_src     = 1'b0;
        alu_control = ALU_ADD;
        imm_ext     = '0;
        IllegalD    = 1'b0;
        case (opcode)
            OP_LW: begin
                reg_write  = 1'b1;
                result_src = 2'b01;
                alu_src    = 1'b1;
                imm_ext    = imm_i;
            end
            OP_SW: begin
                mem_write = 1'b1;
                alu_src   = 1'b1;
                imm_ext   = imm_s;
            end
            OP_R: begin
                if (alu_ok) begin
                    reg_write   = 1'b1;
                    alu_control = alu_op;
                end else begin
                    IllegalD = 1'b1;
                end
            end
            OP_I: begin
                if (alu_ok) begin
                    reg_write   = 1'b1;
                    alu_src     = 1'b1;
                    alu_control = alu_op;
                    imm_ext     = imm_i;
                end else begin
                    IllegalD = 1'b1;
                end
            end
            OP_BEQ: begin
                branch      = 1'b1;
                alu_control = ALU_SUB;
                imm_ext     = imm_b;
            end
            OP_JAL: begin
                reg_write  = 1'b1;
                jump       = 1'b1;
                result_src = 2'b10;
                imm_ext    = imm_j;
            end
            default: IllegalD = 1'b1;
        endcase
    end

    // Register file and ID/EX register. Reset beats flush and write-back.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst) begin
            // NOTE: the register file is architecturally zero after reset, so
            // this memory is cleared explicitly rather than left undefined.
            for (int i = 0; i < NREGS; i++)
                rf[i] <= '0;
            RegWriteE   <= 1'b0;
            ResultSrcE  <= 2'b00;
            MemWriteE   <= 1'b0;
            JumpE       <= 1'b0;
            BranchE     <= 1'b0;
            ALUSrcE     <= 1'b0;
            ALUControlE <= 3'b000;
            RD1E        <= '0;
            RD2E        <= '0;
            ImmExtE     <= '0;
            RdE         <= '0;
            Rs1E        <= '0;
            Rs2E        <= '0;
            PCE         <= '0;
            PCPlus4E    <= '0;
        end else begin
            if (RegWriteW && RDW != 5'd0)
                rf[RDW] <= ResultW;

            if (FlushE) begin
                RegWriteE   <= 1'b0;
                ResultSrcE  <= 2'b00;
                MemWriteE   <= 1'b0;
                JumpE       <= 1'b0;
                BranchE     <= 1'b0;
                ALUSrcE     <= 1'b0;
                ALUControlE <= 3'b000;
                RdE         <= '0;
                Rs1E        <= '0;
                Rs2E        <= '0;
            end else begin
                RegWriteE   <= reg_write;
                ResultSrcE  <= result_src;
                MemWriteE   <= mem_write;
                JumpE       <= jump;
                BranchE     <= branch;
                ALUSrcE     <= alu_src;
                ALUControlE <= alu_control;
                RdE         <= InstrD[11:7];
                Rs1E        <= Rs1D;
                Rs2E        <= Rs2D;
            end

            // Data fields are don't-care in a bubble; load them unconditionally.
            RD1E     <= rd1;
            RD2E     <= rd2;
            ImmExtE  <= imm_ext;
            PCE      <= PCD;
            PCPlus4E <= PCPlus4D;
        end
    end

endmodule

// File: tb/tb_decode_cycle.sv
// -----------------------------------------------------------------------------
// tb_decode_cycle
//   Self-checking bench for decode_cycle. Directed scenarios plus a randomized
//   run compared against a reference model that decodes by instruction class
//   and keeps the register file as a plain array (write applied before read,
//   which is what the same-cycle bypass must look like from outside).
// -----------------------------------------------------------------------------
module tb_decode_cycle;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    typedef struct packed {
        logic        ill;
        logic        rw;
        logic [1:0]  rs;
        logic        mw;
        logic        jmp;
        logic        br;
        logic        asrc;
        logic [2:0]  alu;
        logic        imm_used;
        logic [31:0] imm;
    } ctl_t;

    logic        clk;
    logic        rst;
    logic [31:0] InstrD, PCD, PCPlus4D, ResultW;
    logic        RegWriteW, FlushE;
    logic [4:0]  RDW;
    logic [4:0]  Rs1D, Rs2D;
    logic        IllegalD;
    logic        RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE;
    logic [1:0]  ResultSrcE;
    logic [2:0]  ALUControlE;
    logic [31:0] RD1E, RD2E, ImmExtE, PCE, PCPlus4E;
    logic [4:0]  RdE, Rs1E, Rs2E;

    int checks = 0;
    int errors = 0;

    logic [31:0] mrf [32];

    // Expectations for the E stage after the most recent tick.
    logic [9:0]  e_ctl;
    logic [14:0] e_idx;
    logic [31:0] e_rd1, e_rd2, e_imm, e_pc, e_pcp4;
    logic        e_data_valid, e_imm_valid;

    decode_cycle dut (
        .clk         (clk),
        .rst         (rst),
        .InstrD      (InstrD),
        .PCD         (PCD),
        .PCPlus4D    (PCPlus4D),
        .RegWriteW   (RegWriteW),
        .RDW         (RDW),
        .ResultW     (ResultW),
        .FlushE      (FlushE),
        .Rs1D        (Rs1D),
        .Rs2D        (Rs2D),
        .IllegalD    (IllegalD),
        .RegWriteE   (RegWriteE),
        .ResultSrcE  (ResultSrcE),
        .MemWriteE   (MemWriteE),
        .JumpE       (JumpE),
        .BranchE     (BranchE),
        .ALUSrcE     (ALUSrcE),
        .ALUControlE (ALUControlE),
        .RD1E        (RD1E),
        .RD2E        (RD2E),
        .ImmExtE     (ImmExtE),
        .RdE         (RdE),
        .Rs1E        (Rs1E),
        .Rs2E        (Rs2E),
        .PCE         (PCE),
        .PCPlus4E    (PCPlus4E)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference decoder: classify the instruction, then attach its attributes.
    function automatic ctl_t ref_decode(input logic [31:0] ins);
        ctl_t               c;
        logic               alu_ok;
        logic [2:0]         alu_fn;
        logic signed [11:0] i12;
        logic signed [11:0] s12;
        logic signed [12:0] b13;
        logic signed [20:0] j21;
        c      = '0;
        alu_ok = 1'b1;
        alu_fn = 3'b000;
        case (ins[14:12])
            3'd0:    alu_fn = (ins[6:0] == OP_R && ins[30]) ? 3'b001 : 3'b000;
            3'd2:    alu_fn = 3'b101;
            3'd6:    alu_fn = 3'b011;
            3'd7:    alu_fn = 3'b010;
            default: alu_ok = 1'b0;
        endcase
        i12 = ins[31:20];
        s12 = {ins[31:25], ins[11:7]};
        b13 = {ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
        j21 = {ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
        case (ins[6:0])
            OP_LW: begin
                c.rw = 1; c.rs = 2'b01; c.asrc = 1;
                c.imm_used = 1; c.imm = 32'(i12);
            end
            OP_SW: begin
                c.mw = 1; c.asrc = 1;
                c.imm_used = 1; c.imm = 32'(s12);
            end
            OP_R: begin
                if (alu_ok) begin c.rw = 1; c.alu = alu_fn; end
                else c.ill = 1;
            end
            OP_I: begin
                if (alu_ok) begin
                    c.rw = 1; c.asrc = 1; c.alu = alu_fn;
                    c.imm_used = 1; c.imm = 32'(i12);
                end else c.ill = 1;
            end
            OP_BEQ: begin
                c.br = 1; c.alu = 3'b001;
                c.imm_used = 1; c.imm = 32'(b13);
            end
            OP_JAL: begin
                c.rw = 1; c.jmp = 1; c.rs = 2'b10;
                c.imm_used = 1; c.imm = 32'(j21);
            end
            default: c.ill = 1;
        endcase
        return c;
    endfunction

    task automatic set_in(input logic [31:0] instr, input logic [31:0] pc,
                          input logic flush, input logic rw,
                          input logic [4:0] rdw, input logic [31:0] resw);
        InstrD    = instr;
        PCD       = pc;
        PCPlus4D  = pc + 32'd4;
        FlushE    = flush;
        RegWriteW = rw;
        RDW       = rdw;
        ResultW   = resw;
        #1;
    endtask

    // Advance one clock and update the model from the inputs that were applied.
    task automatic tick();
        ctl_t c;
        @(posedge clk);
        #1;
        if (!rst) begin
            for (int i = 0; i < 32; i++) mrf[i] = '0;
            e_ctl = '0; e_idx = '0; e_rd1 = '0; e_rd2 = '0;
            e_imm = '0; e_pc = '0; e_pcp4 = '0;
            e_data_valid = 1'b1; e_imm_valid = 1'b1;
        end else begin
            if (RegWriteW && RDW != 5'd0) mrf[RDW] = ResultW;
            c = ref_decode(InstrD);
            e_rd1  = mrf[InstrD[19:15]];
            e_rd2  = mrf[InstrD[24:20]];
            e_imm  = c.imm;
            e_pc   = PCD;
            e_pcp4 = PCD + 32'd4;
            e_data_valid = !FlushE;
            e_imm_valid  = !FlushE && c.imm_used;
            if (FlushE) begin
                e_ctl = '0;
                e_idx = '0;
            end else begin
                e_ctl = {c.rw, c.rs, c.mw, c.jmp, c.br, c.asrc, c.alu};
                e_idx = {InstrD[11:7], InstrD[19:15], InstrD[24:20]};
            end
        end
    endtask

    task automatic test_reset();
        logic [31:0] instr;
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            set_in($urandom, $urandom, 1'($urandom), 1'b1, 5'($urandom_range(1, 31)), $urandom);
            tick();
            checks++;
            if ({RegWriteE, ResultSrcE, MemWriteE, JumpE, BranchE, ALUSrcE, ALUControlE,
                 RD1E, RD2E, ImmExtE, RdE, Rs1E, Rs2E, PCE, PCPlus4E} !== '0) begin
                errors++;
                $display("FAIL reset_outputs cycle %0d: RegWriteE=%b MemWriteE=%b RD1E=%h ImmExtE=%h RdE=%0d PCE=%h, all required 0",
                         i, RegWriteE, MemWriteE, RD1E, ImmExtE, RdE, PCE);
            end
        end
        rst = 1'b1;
        // add x0, xi, x(32-i): both operands must read zero after reset.
        for (int i = 1; i < 32; i++) begin
            instr = {7'b0, 5'(32 - i), 5'(i), 3'b000, 5'd0, OP_R};
            set_in(instr, 32'h100, 1'b0, 1'b0, 5'd0, 32'h0);
            tick();
            checks++;
            if (RD1E !== 32'h0 || RD2E !== 32'h0) begin
                errors++;
                $display("FAIL reset_regfile x%0d/x%0d: RD1E=%h RD2E=%h required 0", i, 32 - i, RD1E, RD2E);
            end
        end
    endtask

    task automatic test_addi();
        set_in(32'h00000013, 32'h0, 1'b0, 1'b1, 5'd1, 32'd5);   // write x1=5 under a nop
        tick();
        set_in(32'h00500093, 32'h4, 1'b0, 1'b0, 5'd0, 32'h0);   // addi x1,x0,5
        checks++;
        if (IllegalD !== 1'b0 || Rs1D !== 5'd0) begin
            errors++;
            $display("FAIL addi_comb: IllegalD=%b Rs1D=%0d required 0/0", IllegalD, Rs1D);
        end
        tick();
        checks++;
        if (RegWriteE !== 1'b1 || ALUSrcE !== 1'b1 || ImmExtE !== 32'd5 ||
            RdE !== 5'd1 || ALUControlE !== 3'b000 || RD1E !== 32'h0) begin
            errors++;
            $display("FAIL addi: RegWriteE=%b ALUSrcE=%b ImmExtE=%h RdE=%0d ALUControlE=%b RD1E=%h required 1 1 5 1 000 0",
                     RegWriteE, ALUSrcE, ImmExtE, RdE, ALUControlE, RD1E);
        end
        set_in(32'h00008233, 32'h8, 1'b0, 1'b0, 5'd0, 32'h0);   // add x4,x1,x0
        tick();
        checks++;
        if (RD1E !== 32'd5) begin
            errors++;
            $display("FAIL regfile_x1_read: RD1E=%h required 5", RD1E);
        end
    endtask

    task automatic test_bypass();
        set_in(32'h002081B3, 32'hC, 1'b0, 1'b1, 5'd1, 32'hA5);  // add x3,x1,x2 + write x1
        checks++;
        if (Rs1D !== 5'd1 || Rs2D !== 5'd2) begin
            errors++;
            $display("FAIL bypass_comb: Rs1D=%0d Rs2D=%0d required 1/2", Rs1D, Rs2D);
        end
        tick();
        checks++;
        if (RD1E !== 32'hA5 || Rs2E !== 5'd2 || RdE !== 5'd3 || RD2E !== 32'h0) begin
            errors++;
            $display("FAIL bypass: RD1E=%h Rs2E=%0d RdE=%0d RD2E=%h required a5 2 3 0", RD1E, Rs2E, RdE, RD2E);
        end
        set_in(32'h002081B3, 32'h10, 1'b0, 1'b0, 5'd0, 32'h0);
        tick();
        checks++;
        if (RD1E !== 32'hA5) begin
            errors++;
            $display("FAIL bypass_stored: RD1E=%h required a5", RD1E);
        end
    endtask

    task automatic test_store_branch();
        set_in(32'h0020A423, 32'h20, 1'b0, 1'b0, 5'd0, 32'h0);  // sw x2,8(x1)
        tick();
        checks++;
        if (MemWriteE !== 1'b1 || RegWriteE !== 1'b0 || ImmExtE !== 32'd8 || ALUSrcE !== 1'b1) begin
            errors++;
            $display("FAIL sw: MemWriteE=%b RegWriteE=%b ImmExtE=%h ALUSrcE=%b required 1 0 8 1",
                     MemWriteE, RegWriteE, ImmExtE, ALUSrcE);
        end
        set_in(32'hFE000EE3, 32'h24, 1'b0, 1'b0, 5'd0, 32'h0);  // beq, offset -4
        tick();
        checks++;
        if (BranchE !== 1'b1 || ALUControlE !== 3'b001 || ImmExtE !== 32'hFFFFFFFC || RegWriteE !== 1'b0) begin
            errors++;
            $display("FAIL beq: BranchE=%b ALUControlE=%b ImmExtE=%h RegWriteE=%b required 1 001 fffffffc 0",
                     BranchE, ALUControlE, ImmExtE, RegWriteE);
        end
    endtask

    task automatic test_jal_flush();
        set_in(32'h010000EF, 32'h40, 1'b0, 1'b0, 5'd0, 32'h0);  // jal x1,16
        tick();
        checks++;
        if (JumpE !== 1'b1 || ResultSrcE !== 2'b10 || ImmExtE !== 32'd16 ||
            PCPlus4E !== 32'h44 || PCE !== 32'h40 || RegWriteE !== 1'b1) begin
            errors++;
            $display("FAIL jal: JumpE=%b ResultSrcE=%b ImmExtE=%h PCPlus4E=%h PCE=%h RegWriteE=%b required 1 10 10 44 40 1",
                     JumpE, ResultSrcE, ImmExtE, PCPlus4E, PCE, RegWriteE);
        end
        set_in(32'h010000EF, 32'h40, 1'b1, 1'b1, 5'd5, 32'h1234); // flushed, write still lands
        tick();
        checks++;
        if ({RegWriteE, ResultSrcE, MemWriteE, JumpE, BranchE, ALUSrcE, ALUControlE} !== 10'h0 ||
            {RdE, Rs1E, Rs2E} !== 15'h0) begin
            errors++;
            $display("FAIL jal_flush: RegWriteE=%b JumpE=%b ResultSrcE=%b RdE=%0d Rs1E=%0d Rs2E=%0d required all 0",
                     RegWriteE, JumpE, ResultSrcE, RdE, Rs1E, Rs2E);
        end
        set_in({7'b0, 5'd0, 5'd5, 3'b000, 5'd6, OP_R}, 32'h44, 1'b0, 1'b0, 5'd0, 32'h0);
        tick();
        checks++;
        if (RD1E !== 32'h1234) begin
            errors++;
            $display("FAIL flush_writeback: RD1E=%h required 1234", RD1E);
        end
    endtask

    task automatic test_x0_illegal();
        set_in(32'h00000333, 32'h50, 1'b0, 1'b1, 5'd0, 32'hFFFF); // add x6,x0,x0 + write x0
        tick();
        checks++;
        if (RD1E !== 32'h0 || RD2E !== 32'h0) begin
            errors++;
            $display("FAIL x0_bypass: RD1E=%h RD2E=%h required 0", RD1E, RD2E);
        end
        set_in(32'h00000333, 32'h54, 1'b0, 1'b0, 5'd0, 32'h0);
        tick();
        checks++;
        if (RD1E !== 32'h0) begin
            errors++;
            $display("FAIL x0_write_dropped: RD1E=%h required 0", RD1E);
        end
        set_in(32'hFFFFFFFF, 32'h58, 1'b0, 1'b0, 5'd0, 32'h0);
        checks++;
        if (IllegalD !== 1'b1) begin
            errors++;
            $display("FAIL illegal_comb: IllegalD=%b required 1", IllegalD);
        end
        tick();
        checks++;
        if ({RegWriteE, ResultSrcE, MemWriteE, JumpE, BranchE, ALUSrcE, ALUControlE} !== 10'h0) begin
            errors++;
            $display("FAIL illegal_nop: controls=%b required 0",
                     {RegWriteE, ResultSrcE, MemWriteE, JumpE, BranchE, ALUSrcE, ALUControlE});
        end
    endtask

    task automatic test_random();
        logic [31:0] w;
        ctl_t        c;
        for (int n = 0; n < 400; n++) begin
            w = $urandom;
            case ($urandom_range(0, 6))
                0: w[6:0] = OP_LW;
                1: w[6:0] = OP_SW;
                2: w[6:0] = OP_R;
                3: w[6:0] = OP_I;
                4: w[6:0] = OP_BEQ;
                5: w[6:0] = OP_JAL;
                default: ;
            endcase
            set_in(w, $urandom & 32'hFFFF_FFFC, ($urandom_range(0, 7) == 0),
                   1'($urandom), 5'($urandom), $urandom);
            c = ref_decode(w);
            checks++;
            if (IllegalD !== c.ill || Rs1D !== w[19:15] || Rs2D !== w[24:20]) begin
                errors++;
                $display("FAIL rand_comb #%0d instr=%h: IllegalD=%b Rs1D=%0d Rs2D=%0d required %b %0d %0d",
                         n, w, IllegalD, Rs1D, Rs2D, c.ill, w[19:15], w[24:20]);
            end
            tick();
            checks++;
            if ({RegWriteE, ResultSrcE, MemWriteE, JumpE, BranchE, ALUSrcE, ALUControlE} !== e_ctl) begin
                errors++;
                $display("FAIL rand_ctl #%0d instr=%h: got %b required %b", n, w,
                         {RegWriteE, ResultSrcE, MemWriteE, JumpE, BranchE, ALUSrcE, ALUControlE}, e_ctl);
            end
            checks++;
            if ({RdE, Rs1E, Rs2E} !== e_idx) begin
                errors++;
                $display("FAIL rand_idx #%0d instr=%h: got %h required %h", n, w, {RdE, Rs1E, Rs2E}, e_idx);
            end
            if (e_data_valid) begin
                checks++;
                if (RD1E !== e_rd1 || RD2E !== e_rd2) begin
                    errors++;
                    $display("FAIL rand_operands #%0d instr=%h: RD1E=%h RD2E=%h required %h %h",
                             n, w, RD1E, RD2E, e_rd1, e_rd2);
                end
                checks++;
                if (PCE !== e_pc || PCPlus4E !== e_pcp4) begin
                    errors++;
                    $display("FAIL rand_pc #%0d: PCE=%h PCPlus4E=%h required %h %h", n, PCE, PCPlus4E, e_pc, e_pcp4);
                end
            end
            if (e_imm_valid) begin
                checks++;
                if (ImmExtE !== e_imm) begin
                    errors++;
                    $display("FAIL rand_imm #%0d instr=%h: ImmExtE=%h required %h", n, w, ImmExtE, e_imm);
                end
            end
        end
    endtask

    initial begin
        rst = 1'b0;
        set_in(32'h0, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0);
        for (int i = 0; i < 32; i++) mrf[i] = '0;
        test_reset();
        test_addi();
        test_bypass();
        test_store_branch();
        test_jal_flush();
        test_x0_illegal();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
